bram_vector_writer: RTL
=======================

Name: bram_vector_writer

Overview:
- Write-side counterpart of the layer weight/bias loaders.
- Takes a flat packed vector of N_ELEM elements, each W bits wide, and stores it element by element into BRAM, starting at a programmable base address.
- Used to persist layer outputs or updated parameters so an existing loader pointed at the same address range rebuilds the identical vector.
- Drives the BRAM port signals (en/ren/wen/addr/din) as a master. It does not instantiate the BRAM.

Parameters:
- N_ELEM, 8: number of elements in the vector.
- W, 8: element width in bits.
- ADDR_WIDTH, 18: BRAM address width.
- RD_LAT, 2: BRAM read latency in cycles. Used only by the optional readback check.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a transfer. Sampled only in IDLE or DONE.
- base_addr  in  ADDR_WIDTH  first BRAM address. Captured on the start edge.
- data_in  in  N_ELEM*W  packed vector. Element i is data_in[i*W +: W]. Captured on the start edge.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  level, high while in DONE.
- bram_en  out  1  BRAM enable.
- bram_wen  out  1  BRAM write enable.
- bram_ren  out  1  BRAM read enable.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_din  out  W  BRAM write data.
- bram_dout  in  W  BRAM read data. Ignored unless READBACK_CHECK_EN is defined.
- verify_err  out  1  sticky readback mismatch flag. Tied 0 unless READBACK_CHECK_EN is defined.

Behaviour:
- Reset (async, any state, including mid-transfer):
  - state = IDLE.
  - All outputs = 0.
  - Element index = 0.
  - Shadow vector cleared.
  - A partially written range is left as-is; no rollback.
- States: IDLE, WRITE, DONE. With READBACK_CHECK_EN, also READ and DRAIN.
- IDLE/DONE + start=1 at edge k:
  - Capture data_in and base_addr into shadow registers.
  - idx = 0; go to WRITE; done drops at k+1.
  - start=0 holds the current state. DONE keeps done=1 indefinitely.
- WRITE:
  - Each cycle drive bram_en=1, bram_wen=1, bram_ren=0, bram_addr=base+idx, bram_din=shadow[idx*W +: W].
  - Element i is presented during cycle k+1+i.
  - After idx = N_ELEM-1:
    - Without the feature: go to DONE, drop en/wen.
    - With the feature: go to READ.
- Latency: done=1 from cycle k+N_ELEM+1 (default N_ELEM=8: 9 cycles after the start edge).
- Address arithmetic is modulo 2^ADDR_WIDTH. base=2^ADDR_WIDTH-1 with idx=1 writes address 0.
- Mid-transfer inputs:
  - start while busy is ignored.
  - data_in and base_addr changes after the capture edge have no effect.
- Exactly one BRAM access per cycle. wen and ren are never high together.
- N_ELEM=1: a single write cycle, then DONE.
- Packing order is LSB-first, matching the loaders' data_out layout.

Optional Feature:
- Macro READBACK_CHECK_EN.
- Defined:
  - READ issues N_ELEM reads at base..base+N_ELEM-1 (bram_en=1, bram_ren=1, bram_wen=0), one per cycle.
  - Each expected element is delayed RD_LAT cycles through a pipe and compared with bram_dout.
  - DRAIN holds en=1, ren=0 for RD_LAT cycles to collect the last RD_LAT words, then goes to DONE.
  - Any mismatch sets verify_err. It stays set until the next start capture or reset.
  - Latency to done = 2*N_ELEM+RD_LAT+1 (19 for defaults).
- Undefined:
  - No READ or DRAIN states.
  - bram_ren is always 0, bram_dout is unused, verify_err = 0.

Decomposition:
- Shared package nn_bram_pkg holds:
  - state encoding localparams (IDLE=0, WRITE=1, READ=2, DRAIN=3, DONE=4, 3 bits);
  - BRAM_RD_LAT=2;
  - default W=8 and ADDR_WIDTH=18.
- One natural sub-module, rdback_pipe: an RD_LAT-deep shift register of {valid, expected[W-1:0]}. It is instantiated only under READBACK_CHECK_EN.

Test Plan:
- Basic write:
  - Stimulus: N_ELEM=8, base=147496, data_in=64'h0807060504030201, start pulse.
  - Expected: wen high exactly 8 cycles; addr 147496..147503 carry din 01..08; done=1 at cycle 9 and held; busy=0.
- Wrap-around:
  - Stimulus: base=18'h3FFFE, N_ELEM=4.
  - Expected: addresses 3FFFE, 3FFFF, 00000, 00001.
- Start while busy:
  - Stimulus: second start plus new data_in at cycle 3.
  - Expected: ignored; original 8 values written; single done.
- Reset mid-transfer:
  - Stimulus: rst asserted after the 3rd write.
  - Expected: all outputs 0 immediately (async); IDLE; a later start rewrites from base.
- Readback check (READBACK_CHECK_EN):
  - Stimulus: BRAM model returns the written data.
  - Expected: verify_err=0 and done at cycle 19.
  - Stimulus: model corrupts address base+5.
  - Expected: verify_err=1 and stays high through DONE until the next start.
- Back-to-back:
  - Stimulus: start issued in DONE with new base=100.
  - Expected: done drops next cycle; new transfer to 100..107 completes normally.

Source files
------------

// File: rtl/nn_bram_pkg.sv
// Shared definitions for the NN BRAM loader/writer family.
package nn_bram_pkg;

   // Transfer state encoding shared by the BRAM masters.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } bram_xfer_state_e;

   localparam int unsigned BRAM_RD_LAT    = 2;
   localparam int unsigned DEF_W          = 8;
   localparam int unsigned DEF_ADDR_WIDTH = 18;

endpackage

// File: rtl/bram_vector_writer_rdback_pipe.sv
// rdback_pipe: RD_LAT-deep shift register of {valid, expected element}.
// Aligns expected readback data with the BRAM read latency.
module rdback_pipe
   import nn_bram_pkg::*;
#(
   parameter int unsigned RD_LAT = BRAM_RD_LAT,
   parameter int unsigned W      = DEF_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic [W:0] pipe_q [RD_LAT];

   // Shift {valid, data} one stage per cycle; reset flushes all stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= {valid_i, data_i};
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign {valid_o, data_o} = pipe_q[RD_LAT-1];

endmodule

// File: rtl/bram_vector_writer.sv
// bram_vector_writer: stores a packed N_ELEM x W vector into BRAM, one
// element per cycle from a programmable base address (LSB element first).
// Optional READBACK_CHECK_EN: reads the range back after writing and sets a
// sticky verify_err on any mismatch.
module bram_vector_writer
   import nn_bram_pkg::*;
#(
   parameter int unsigned N_ELEM     = 8,
   parameter int unsigned W          = DEF_W,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned RD_LAT     = BRAM_RD_LAT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [N_ELEM*W-1:0]   data_in,
   output logic                  busy,
   output logic                  done,
   output logic                  bram_en,
   output logic                  bram_wen,
   output logic                  bram_ren,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [W-1:0]          bram_din,
   input  logic [W-1:0]          bram_dout,
   output logic                  verify_err
);

   localparam int unsigned   IW       = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(N_ELEM - 1);

   bram_xfer_state_e        state_q;
   logic [N_ELEM*W-1:0]     shadow_q;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [IW-1:0]           idx_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    en_q;
   logic                    wen_q;
   logic                    ren_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [W-1:0]            din_q;

   logic [IW-1:0]           idx_d;
   logic [ADDR_WIDTH-1:0]   addr_d;
   logic [W-1:0]            elem_d;

   // Next element index, its address (modulo 2^ADDR_WIDTH) and its data.
   assign idx_d  = idx_q + IW'(1);
   assign addr_d = base_q + ADDR_WIDTH'(idx_d);
   assign elem_d = shadow_q[idx_d*W +: W];

`ifdef READBACK_CHECK_EN
   localparam int unsigned DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   logic [DW-1:0] drain_q;
   logic          verr_q;
   logic          pipe_valid;
   logic [W-1:0]  pipe_data;

   // Fed from the registered read strobe so the expected word reaches the
   // last stage in the same cycle the BRAM presents it on bram_dout.
   rdback_pipe #(
      .RD_LAT (RD_LAT),
      .W      (W)
   ) u_rdback_pipe (
      .clk     (clk),
      .rst     (rst),
      .valid_i (ren_q),
      .data_i  (shadow_q[idx_q*W +: W]),
      .valid_o (pipe_valid),
      .data_o  (pipe_data)
   );

   assign verify_err = verr_q;
`else
   logic unused_inputs;
   assign unused_inputs = ^{bram_dout, RD_LAT[0]};
   assign verify_err    = 1'b0;
`endif

   // Transfer FSM with registered BRAM-port and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         base_q   <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         en_q     <= 1'b0;
         wen_q    <= 1'b0;
         ren_q    <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
`ifdef READBACK_CHECK_EN
         drain_q  <= '0;
         verr_q   <= 1'b0;
`endif
      end else begin
`ifdef READBACK_CHECK_EN
         if (pipe_valid && (pipe_data != bram_dout)) begin
            verr_q <= 1'b1;
         end
`endif
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q  <= WRITE;
                  shadow_q <= data_in;
                  base_q   <= base_addr;
                  idx_q    <= '0;
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
                  en_q     <= 1'b1;
                  wen_q    <= 1'b1;
                  ren_q    <= 1'b0;
                  addr_q   <= base_addr;
                  din_q    <= data_in[W-1:0];
`ifdef READBACK_CHECK_EN
                  verr_q   <= 1'b0;
`endif
               end
            end
            WRITE: begin
               if (idx_q == IDX_LAST) begin
`ifdef READBACK_CHECK_EN
                  state_q <= READ;
                  idx_q   <= '0;
                  wen_q   <= 1'b0;
                  ren_q   <= 1'b1;
                  addr_q  <= base_q;
                  din_q   <= '0;
`else
                  state_q <= DONE;
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  en_q    <= 1'b0;
                  wen_q   <= 1'b0;
                  addr_q  <= '0;
                  din_q   <= '0;
`endif
               end else begin
                  idx_q  <= idx_d;
                  addr_q <= addr_d;
                  din_q  <= elem_d;
               end
            end
`ifdef READBACK_CHECK_EN
            READ: begin
               if (idx_q == IDX_LAST) begin
                  state_q <= DRAIN;
                  idx_q   <= '0;
                  ren_q   <= 1'b0;
                  addr_q  <= '0;
                  drain_q <= '0;
               end else begin
                  idx_q  <= idx_d;
                  addr_q <= addr_d;
               end
            end
            DRAIN: begin
               if (drain_q == DW'(RD_LAT - 1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  en_q    <= 1'b0;
               end else begin
                  drain_q <= drain_q + DW'(1);
               end
            end
`endif
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               en_q    <= 1'b0;
               wen_q   <= 1'b0;
               ren_q   <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign bram_en   = en_q;
   assign bram_wen  = wen_q;
   assign bram_ren  = ren_q;
   assign bram_addr = addr_q;
   assign bram_din  = din_q;

endmodule
